wb_trace_capture: RTL and testbench
===================================

# wb_trace_capture

Capture and run-control block for the Fase 3 core. It enables the core for a programmed number of clock cycles, records every register-file writeback the core makes, and tags each one with its cycle number. The records sit in a small FIFO until a host or bench drains them through a valid/ready port. The block is the reading end of the core's writeback interface and replaces hand-toggled clock stimulus with a bounded, self-terminating run.

## Interface
- DATA_W, 32, writeback data width
- REG_AW, 5, register address width
- CYC_W, 16, cycle-stamp and cycle-limit width
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request
- max_cycles  in  CYC_W  run length, sampled only when start is accepted
- wb_en  in  1  core register-write strobe
- wb_addr  in  REG_AW  core destination register
- wb_data  in  DATA_W  core write data
- core_en  out  1  core clock-enable
- out_valid  out  1  FIFO head holds a record
- out_ready  in  1  host accepts the head record
- out_cycle  out  CYC_W  cycle stamp of the head record
- out_addr  out  REG_AW  register address of the head record
- out_data  out  DATA_W  data of the head record
- fifo_count  out  $clog2(DEPTH)+1  number of records held
- overflow  out  1  sticky flag: at least one record was dropped
- done  out  1  run finished and FIFO drained

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE with start=1:
  - latch max_cycles into lim;
  - clear cyc and overflow;
  - go to RUN, or go to DRAIN if max_cycles=0.
- start is ignored in RUN and DRAIN.
- RUN:
  - core_en=1;
  - cyc increments by 1 each cycle, starting at 0;
  - when cyc==lim-1, the next state is DRAIN.
- DRAIN: core_en=0. Go to DONE at the first edge where fifo_count==0.
- DONE: done=1. DONE is held until the next start.
- Capture (push) happens only when state==RUN, wb_en=1 and wb_addr!=0. Writes to $zero are never recorded.
- Each record is {cyc, wb_addr, wb_data}, sampled in the same cycle.
- Pop happens when out_valid && out_ready.
- The FIFO is first-word-fall-through: the out_* buses show the head record whenever out_valid=1. out_* contents are don't-care when out_valid=0.
- FIFO full and push without pop: the record is dropped, overflow is set, and fifo_count stays at DEPTH.
- FIFO full with push and pop in the same cycle: both are performed and fifo_count stays at DEPTH. Nothing is dropped.
- FIFO empty with push and pop in the same cycle: no pop, because out_valid=0. The push is performed.
- The FIFO read and write pointers wrap modulo DEPTH.
- The cyc counter does not wrap within a run, because lim ≤ 2^CYC_W−1.
- overflow is cleared only by reset or by an accepted start.

## Timing
- Reset values (asynchronous, immediate on rst_n=0):
  - state=IDLE, core_en=0, done=0;
  - out_valid=0, fifo_count=0, overflow=0;
  - cyc=0, lim=0, FIFO pointers=0;
  - out_cycle, out_addr and out_data = 0.
- Reset asserted mid-run drops all records and returns to the reset values above.
- core_en is decoded from registered state only, with no combinational path from start. It rises one cycle after start is sampled and is high for exactly lim consecutive cycles.
- Push latency: a record captured at edge N gives out_valid=1 after edge N, i.e. in cycle N+1.
- Pop: the record is retired at the edge where out_valid && out_ready. The next record, if any, appears in the following cycle.
- done rises one cycle after the edge at which DRAIN sees fifo_count==0.
- With lim ≥ 1, no records and out_ready=1: done rises lim+1 cycles after core_en rises.
- out_valid does not depend combinationally on out_ready.
- out_ready may be held high permanently.

## Test plan
- Reset values and restart:
  - Stimulus: rst_n=0 for 3 cycles, then release.
  - Required: all outputs at their reset values.
  - Stimulus: start with max_cycles=4, no writes, out_ready=1.
  - Required: core_en high for 4 cycles, done=1, fifo_count=0.
  - Stimulus: a second start.
  - Required: done falls and core_en is high for 4 more cycles.
- Basic capture:
  - Stimulus: max_cycles=6, writes at cyc 1 (addr 8, 0x0000_000A) and cyc 3 (addr 9, 0xFFFF_FFF6), out_ready=1.
  - Required: records {1,8,0x0000000A} then {3,9,0xFFFFFFF6}, in that order, then done=1.
- $zero filter:
  - Stimulus: wb_en=1 with addr 0 and data 0x1234 at cyc 2, plus addr 2 and data 5 at cyc 2 in a separate run.
  - Required: only {2,2,5} is recorded in that run; addr 0 never appears.
- Overflow:
  - Stimulus: out_ready=0, DEPTH=8, writes to addr 1 on cyc 0..9 with data = cyc.
  - Required: fifo_count=8 and overflow=1.
  - Stimulus: drain with out_ready=1.
  - Required: data 0..7 in order, then done=1, with overflow still set.
- Full simultaneous push/pop:
  - Stimulus: fill to 8, then assert out_ready=1 while writes continue every cycle.
  - Required: fifo_count stays 8, overflow stays 0, and no cycle stamp is missing.
- Reset mid-run and zero length:
  - Stimulus: max_cycles=20, assert rst_n=0 at cyc 7 with 3 records held.
  - Required: all reset values immediately.
  - Stimulus: start with max_cycles=0.
  - Required: core_en never rises and done=1 two cycles after start.

Source files
------------

// File: rtl/wb_trace_capture.sv
// wb_trace_capture: bounded core run control with a cycle-stamped writeback trace FIFO
module wb_trace_capture #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CYC_W  = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [CYC_W-1:0]         max_cycles,
   input  logic                     wb_en,
   input  logic [REG_AW-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   output logic                     core_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CYC_W-1:0]         out_cycle,
   output logic [REG_AW-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     done
);
   localparam int PW = $clog2(DEPTH);
   localparam int RW = CYC_W + REG_AW + DATA_W;
   localparam logic [PW:0] FULL = DEPTH[PW:0];
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state;
   logic [CYC_W-1:0] cyc, lim;
   logic [PW-1:0] wp, rp;
   logic [RW-1:0] mem [DEPTH];
   logic [RW-1:0] head;
   logic push, pop, wr;
   assign out_valid = fifo_count != '0;
   always_comb begin
      push = state == RUN && wb_en && wb_addr != '0;
      pop  = out_valid && out_ready;
      wr   = push && (fifo_count != FULL || pop);
      head = out_valid ? mem[rp] : '0;
   end
   assign {out_cycle, out_addr, out_data} = head;
   always_ff @(posedge clk)
      if (wr) mem[wp] <= {cyc, wb_addr, wb_data};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         core_en    <= 1'b0;
         done       <= 1'b0;
         cyc        <= '0;
         lim        <= '0;
         wp         <= '0;
         rp         <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         wp         <= wp + PW'(wr);
         rp         <= rp + PW'(pop);
         fifo_count <= fifo_count + (PW+1)'(wr) - (PW+1)'(pop);
         if (push && !wr) overflow <= 1'b1;
         case (state)
            IDLE, DONE:
               if (start) begin
                  lim      <= max_cycles;
                  cyc      <= '0;
                  overflow <= 1'b0;
                  done     <= 1'b0;
                  core_en  <= max_cycles != '0;
                  state    <= max_cycles == '0 ? DRAIN : RUN;
               end
            RUN:
               if (cyc == lim - CYC_W'(1)) begin
                  state   <= DRAIN;
                  core_en <= 1'b0;
               end else cyc <= cyc + CYC_W'(1);
            DRAIN:
               if (fifo_count == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_wb_trace_capture.sv
// tb_wb_trace_capture: directed run/capture/overflow/reset checks for wb_trace_capture
module tb_wb_trace_capture;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] max_cycles = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        out_ready = 1'b0;
   logic        core_en, out_valid, overflow, done;
   logic [15:0] out_cycle;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic [3:0]  fifo_count;
   int vectors = 0;
   int errs = 0;

   wb_trace_capture #(.DATA_W(32), .REG_AW(5), .CYC_W(16), .DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .max_cycles(max_cycles),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .core_en(core_en), .out_valid(out_valid), .out_ready(out_ready),
      .out_cycle(out_cycle), .out_addr(out_addr), .out_data(out_data),
      .fifo_count(fifo_count), .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
      wb_en = en;
      wb_addr = a;
      wb_data = d;
   endtask

   // leaves the bench at the negedge of the first RUN cycle (cyc 0)
   task automatic start_run(input logic [15:0] m);
      start = 1'b1;
      max_cycles = m;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      chk(tag, done, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_core_en"}, core_en, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_fifo_count"}, fifo_count, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_out_cycle"}, out_cycle, 0);
      chk({tag, "_out_addr"}, out_addr, 0);
      chk({tag, "_out_data"}, out_data, 0);
   endtask

   task automatic chk_rec(input string tag, input logic [15:0] c, input logic [4:0] a, input logic [31:0] d);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_cycle"}, out_cycle, c);
      chk({tag, "_addr"}, out_addr, a);
      chk({tag, "_data"}, out_data, d);
   endtask

   initial begin
      repeat (3) step();
      chk_reset("rst_hold");
      rst_n = 1'b1;
      step();
      chk_reset("rst_rel");
      // run of 4 with no writes
      out_ready = 1'b1;
      start_run(16'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("run4_core_en_%0d", i), core_en, 1);
         step();
      end
      chk("run4_drain_core_en", core_en, 0);
      chk("run4_drain_done", done, 0);
      step();
      chk("run4_done", done, 1);
      chk("run4_count", fifo_count, 0);
      // restart from DONE
      start_run(16'd4);
      chk("rerun_done_low", done, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rerun_core_en_%0d", i), core_en, 1);
         step();
      end
      chk("rerun_core_en_off", core_en, 0);
      wait_done("rerun_done");
      // basic capture
      start_run(16'd6);
      step();
      wb(1'b1, 5'd8, 32'h0000_000A);
      step();
      wb(1'b0, 5'd0, 32'd0);
      chk_rec("cap1", 16'd1, 5'd8, 32'h0000_000A);
      step();
      chk("cap1_popped", out_valid, 0);
      wb(1'b1, 5'd9, 32'hFFFF_FFF6);
      step();
      wb(1'b0, 5'd0, 32'd0);
      chk_rec("cap2", 16'd3, 5'd9, 32'hFFFF_FFF6);
      wait_done("cap_done");
      chk("cap_overflow", overflow, 0);
      // write to $zero is filtered
      start_run(16'd4);
      step();
      step();
      wb(1'b1, 5'd0, 32'h1234);
      step();
      wb(1'b0, 5'd0, 32'd0);
      chk("zero_valid", out_valid, 0);
      chk("zero_count", fifo_count, 0);
      wait_done("zero_done");
      start_run(16'd4);
      step();
      step();
      wb(1'b1, 5'd2, 32'd5);
      step();
      wb(1'b0, 5'd0, 32'd0);
      chk_rec("reg2", 16'd2, 5'd2, 32'd5);
      step();
      chk("reg2_only", out_valid, 0);
      wait_done("reg2_done");
      // overflow: 10 writes into an 8-deep FIFO with no draining
      out_ready = 1'b0;
      start_run(16'd12);
      for (int k = 0; k < 10; k++) begin
         wb(1'b1, 5'd1, 32'(k));
         step();
      end
      wb(1'b0, 5'd0, 32'd0);
      chk("ovf_count", fifo_count, 8);
      chk("ovf_flag", overflow, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ovf_data_%0d", i), out_data, i);
         chk($sformatf("ovf_cycle_%0d", i), out_cycle, i);
         step();
      end
      chk("ovf_empty", out_valid, 0);
      wait_done("ovf_done");
      chk("ovf_sticky", overflow, 1);
      // full FIFO with simultaneous push and pop
      out_ready = 1'b0;
      start_run(16'd20);
      for (int c = 0; c < 8; c++) begin
         wb(1'b1, 5'd3, 32'(c));
         step();
      end
      chk("full_count", fifo_count, 8);
      chk("full_ovf_new_run", overflow, 0);
      out_ready = 1'b1;
      for (int c = 8; c < 16; c++) begin
         chk($sformatf("pp_count_%0d", c), fifo_count, 8);
         chk($sformatf("pp_cycle_%0d", c), out_cycle, c - 8);
         chk($sformatf("pp_data_%0d", c), out_data, c - 8);
         wb(1'b1, 5'd3, 32'(c));
         step();
      end
      wb(1'b0, 5'd0, 32'd0);
      for (int i = 8; i < 16; i++) begin
         chk($sformatf("pp_drain_cycle_%0d", i), out_cycle, i);
         step();
      end
      chk("pp_empty", out_valid, 0);
      chk("pp_overflow", overflow, 0);
      wait_done("pp_done");
      // reset in the middle of a run
      out_ready = 1'b0;
      start_run(16'd20);
      for (int c = 0; c < 7; c++) begin
         wb(c < 3, 5'd4, 32'(c + 100));
         step();
      end
      wb(1'b0, 5'd0, 32'd0);
      chk("mid_count", fifo_count, 3);
      chk("mid_core_en", core_en, 1);
      #1 rst_n = 1'b0;
      #1 chk_reset("mid_rst");
      step();
      rst_n = 1'b1;
      step();
      // zero-length run
      out_ready = 1'b1;
      start_run(16'd0);
      chk("zl_core_en_1", core_en, 0);
      chk("zl_done_1", done, 0);
      step();
      chk("zl_core_en_2", core_en, 0);
      chk("zl_done_2", done, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
